bsg_arb_oldest_first: RTL and testbench

// Age-tracking scheduler that shares one downstream resource among inputs_p requesters.

---
 rtl/bsg_arb_oldest_first.sv | 112 +++++++++++
 tb/tb_bsg_arb_oldest_first.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bsg_arb_oldest_first.sv
// Oldest-first arbiter: per-requester saturating wait-age counters, grant to the
// oldest pending request, ties broken round-robin starting after the last winner.

module bsg_arb_oldest_first_age #(
    parameter int age_width_p = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   req_i,
    input  logic                   grant_i,
    output logic [age_width_p-1:0] age_o,
    output logic                   sat_o
);
    localparam logic [age_width_p-1:0] age_max_lp = '1;

    logic [age_width_p-1:0] age_q, age_d;

    // A withdrawn or served request forgets its age; waiting ones count up and hold at max.
    always_comb begin
        age_d = age_q;
        if (!req_i || grant_i)
            age_d = '0;
        else if (age_q != age_max_lp)
            age_d = age_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) age_q <= '0;
        else            age_q <= age_d;
    end

    assign age_o = age_q;
    assign sat_o = (age_q == age_max_lp);
endmodule

module bsg_arb_oldest_first #(
    parameter int inputs_p    = 4,
    parameter int age_width_p = 4
) (
    input  logic                                          clk_i,
    input  logic                                          reset_n_i,
    input  logic [inputs_p-1:0]                           reqs_i,
    input  logic                                          ready_i,
    output logic [inputs_p-1:0]                           grants_o,
    output logic                                          v_o,
    output logic [((inputs_p > 1) ? $clog2(inputs_p) : 1)-1:0] tag_o,
    output logic [age_width_p-1:0]                        win_age_o,
    output logic [inputs_p-1:0]                           starve_o
);
    localparam int tag_w_lp = (inputs_p > 1) ? $clog2(inputs_p) : 1;

    logic [inputs_p-1:0][age_width_p-1:0] age;
    logic [inputs_p-1:0]                  sat;
    logic [tag_w_lp-1:0]                  last_q;

    logic                   win_found;
    logic [tag_w_lp-1:0]    win_idx;
    logic [age_width_p-1:0] win_age;
    logic                   grant_v;

    for (genvar i = 0; i < inputs_p; i++) begin : g_lane
        bsg_arb_oldest_first_age #(.age_width_p(age_width_p)) u_age (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .req_i     (reqs_i[i]),
            .grant_i   (grants_o[i]),
            .age_o     (age[i]),
            .sat_o     (sat[i])
        );
    end

    // Scan in round-robin priority order; a strict '>' keeps the earliest index on age ties.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_age   = '0;
        for (int k = 0; k < inputs_p; k++) begin
            int idx;
            idx = int'(last_q) + 1 + k;
            if (idx >= inputs_p) idx = idx - inputs_p;
            if (reqs_i[idx] && (!win_found || age[idx] > win_age)) begin
                win_found = 1'b1;
                win_idx   = tag_w_lp'(idx);
                win_age   = age[idx];
            end
        end
    end

    // Outputs are gated by reset so they fall the moment reset asserts, without a clock.
    assign grant_v = win_found & ready_i & reset_n_i;

    always_comb begin
        grants_o = '0;
        if (grant_v) grants_o[win_idx] = 1'b1;
    end

    assign v_o       = grant_v;
    assign tag_o     = grant_v ? win_idx : '0;
    assign win_age_o = grant_v ? win_age : '0;
    assign starve_o  = sat & {inputs_p{reset_n_i}};

    if (inputs_p == 1) begin : g_single
        assign last_q = '0;
    end else begin : g_multi
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i)
                last_q <= tag_w_lp'(inputs_p - 1);
            else if (grant_v)
                last_q <= win_idx;
        end
    end
endmodule

// File: tb/tb_bsg_arb_oldest_first.sv
// Directed bench for bsg_arb_oldest_first with 4 requesters and 3-bit ages.

module tb_bsg_arb_oldest_first;
    localparam int N  = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  reqs = '0;
    logic          ready = 1'b0;
    logic [N-1:0]  grants;
    logic          v;
    logic [1:0]    tag;
    logic [AW-1:0] win_age;
    logic [N-1:0]  starve;

    int n_chk = 0;
    int n_bad = 0;
    int gcnt [N];

    bsg_arb_oldest_first #(.inputs_p(N), .age_width_p(AW)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .reqs_i    (reqs),
        .ready_i   (ready),
        .grants_o  (grants),
        .v_o       (v),
        .tag_o     (tag),
        .win_age_o (win_age),
        .starve_o  (starve)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Async reset pulse between edges; outputs must drop with no clock.
    task automatic rst_pulse;
        rst_n = 1'b0;
        #2;
        chk("rst_grants", 32'(grants), 32'h0);
        chk("rst_v", 32'(v), 32'h0);
        chk("rst_starve", 32'(starve), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset holds outputs low even with everything requesting.
        reqs  = 4'b1111;
        ready = 1'b1;
        #3;
        chk("por_grants", 32'(grants), 32'h0);
        chk("por_v", 32'(v), 32'h0);
        chk("por_tag", 32'(tag), 32'h0);
        chk("por_win_age", 32'(win_age), 32'h0);
        chk("por_starve", 32'(starve), 32'h0);
        tick;

        // Single requester
        rst_pulse;
        reqs  = 4'b0001;
        ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t1_grants", 32'(grants), 32'h1);
            chk("t1_tag", 32'(tag), 32'h0);
            chk("t1_win_age", 32'(win_age), 32'h0);
            tick;
        end

        // Round-robin from reset
        rst_pulse;
        reqs = 4'b1111;
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        for (int c = 0; c < 8; c++) begin
            logic [N-1:0] e;
            e = N'(1 << (c % 4));
            @(negedge clk);
            chk("t2_grants", 32'(grants), 32'(e));
            for (int i = 0; i < N; i++) if (grants[i]) gcnt[i]++;
            tick;
        end
        for (int i = 0; i < N; i++) chk("t2_count", 32'(gcnt[i]), 32'd2);

        // Reset mid-run, between edges
        rst_n = 1'b0;
        #2;
        chk("t6_grants_low", 32'(grants), 32'h0);
        chk("t6_v_low", 32'(v), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_first_grant", 32'(grants), 32'h1);
        chk("t6_first_tag", 32'(tag), 32'h0);
        tick;

        // Saturation while blocked
        rst_pulse;
        reqs  = 4'b0110;
        ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t3_grants_blk", 32'(grants), 32'h0);
            chk("t3_starve", 32'(starve), (k >= 7) ? 32'h6 : 32'h0);
            tick;
        end
        ready = 1'b1;
        @(negedge clk);
        chk("t3_grant_a", 32'(grants), 32'h2);
        chk("t3_win_age_a", 32'(win_age), 32'h7);
        chk("t3_starve_a", 32'(starve), 32'h6);
        tick;
        @(negedge clk);
        chk("t3_grant_b", 32'(grants), 32'h4);
        chk("t3_tag_b", 32'(tag), 32'h2);
        chk("t3_starve_b", 32'(starve), 32'h4);
        tick;

        // Age beats pointer
        rst_pulse;
        reqs  = 4'b0001;
        ready = 1'b0;
        repeat (5) tick;
        reqs  = 4'b1001;
        ready = 1'b1;
        @(negedge clk);
        chk("t4_grant_a", 32'(grants), 32'h1);
        chk("t4_win_age_a", 32'(win_age), 32'h5);
        tick;
        @(negedge clk);
        chk("t4_grant_b", 32'(grants), 32'h8);
        chk("t4_tag_b", 32'(tag), 32'h3);
        chk("t4_win_age_b", 32'(win_age), 32'h1);
        tick;

        // Withdrawal loses age
        rst_pulse;
        reqs  = 4'b0100;
        ready = 1'b0;
        repeat (4) tick;
        reqs = 4'b0000;
        tick;
        reqs  = 4'b1100;
        ready = 1'b1;
        @(negedge clk);
        chk("t5_grant_a", 32'(grants), 32'h4);
        chk("t5_win_age_a", 32'(win_age), 32'h0);
        tick;
        @(negedge clk);
        chk("t5_grant_b", 32'(grants), 32'h8);
        chk("t5_win_age_b", 32'(win_age), 32'h1);
        // Dropping ready hides the grant
        ready = 1'b0;
        #1;
        chk("t5_v_blk", 32'(v), 32'h0);
        chk("t5_tag_blk", 32'(tag), 32'h0);
        tick;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
